// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR filter core and its adder tree.
package fir_pkg;

  // Adder-structure selectors for the TYPE parameter.
  localparam string TypeNormal = "NORMAL";
  localparam string TypeTree   = "TREE";

  // Full-precision output width: product width plus growth for N+1 terms, with headroom.
  function automatic int unsigned fir_width_y(input int unsigned width_x,
                                              input int unsigned width_b,
                                              input int unsigned n);
    return width_x + width_b + n + 1;
  endfunction

  // Width of a single signed sample-by-coefficient product.
  function automatic int unsigned fir_width_p(input int unsigned width_x,
                                              input int unsigned width_b);
    return width_x + width_b;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Balanced binary adder tree over COUNT packed operands of WIDTH bits each.
// Two's-complement addition is width-preserving, so signed operands sum correctly
// as long as WIDTH already has room for the full result.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int unsigned COUNT = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic [COUNT*WIDTH-1:0] operands,
  output logic [WIDTH-1:0]       sum
);

  if (COUNT == 1) begin : g_leaf
    assign sum = operands;
  end else begin : g_split
    // Lower half gets the smaller share when COUNT is odd.
    localparam int unsigned COUNT_LO = COUNT / 2;
    localparam int unsigned COUNT_HI = COUNT - COUNT_LO;

    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] sum_hi;

    fir_adder_tree #(
      .COUNT(COUNT_LO),
      .WIDTH(WIDTH)
    ) u_lo (
      .operands(operands[COUNT_LO*WIDTH-1:0]),
      .sum     (sum_lo)
    );

    fir_adder_tree #(
      .COUNT(COUNT_HI),
      .WIDTH(WIDTH)
    ) u_hi (
      .operands(operands[COUNT*WIDTH-1:COUNT_LO*WIDTH]),
      .sum     (sum_hi)
    );

    assign sum = sum_lo + sum_hi;
  end

endmodule

// File: rtl/fir_filter_core.sv
// Direct-form FIR filter, N+1 taps with constant signed coefficients B.
// Tap 0 is the live input, so y responds to x in the same cycle.
module fir_filter_core
  import fir_pkg::*;
#(
  parameter int unsigned         N       = 3,
  parameter string               TYPE    = TypeNormal,
  parameter int unsigned         WIDTH_X = 4,
  parameter int unsigned         WIDTH_B = 4,
  parameter logic [WIDTH_B-1:0]  B [N+1] = '{4'd1, 4'd2, 4'd3, 4'd4},
  localparam int unsigned        WIDTH_Y = fir_width_y(WIDTH_X, WIDTH_B, N)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic signed [WIDTH_X-1:0] x,
  output logic signed [WIDTH_Y-1:0] y
);

  localparam int unsigned WIDTH_P = fir_width_p(WIDTH_X, WIDTH_B);
  // Keep the register array non-empty when N=0; it is then tied off and unused.
  localparam int unsigned DEPTH   = (N > 0) ? N : 1;

  // z_q[i] holds x delayed by i+1 cycles.
  logic signed [WIDTH_X-1:0] z_q   [DEPTH];
  logic signed [WIDTH_X-1:0] taps  [N+1];
  logic signed [WIDTH_Y-1:0] prods [N+1];

  if (N > 0) begin : g_delay
    // Delay line: shift one sample per clock, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < int'(N); i++) z_q[i] <= '0;
      end else begin
        z_q[0] <= x;
        for (int i = 1; i < int'(N); i++) z_q[i] <= z_q[i-1];
      end
    end
  end else begin : g_no_delay
    assign z_q[0] = '0;
  end

  // Tap selection and exact signed products, sign-extended to the output width.
  always_comb begin
    taps[0] = x;
    for (int i = 1; i <= int'(N); i++) taps[i] = z_q[i-1];
    for (int i = 0; i <= int'(N); i++) begin
      prods[i] = WIDTH_Y'(WIDTH_P'(taps[i]) * WIDTH_P'($signed(B[i])));
    end
  end

  if (TYPE == TypeTree) begin : g_tree
    logic [(N+1)*WIDTH_Y-1:0] flat;
    logic [WIDTH_Y-1:0]       tree_sum;

    for (genvar i = 0; i <= N; i++) begin : g_pack
      assign flat[i*WIDTH_Y +: WIDTH_Y] = prods[i];
    end

    fir_adder_tree #(
      .COUNT(N + 1),
      .WIDTH(WIDTH_Y)
    ) u_tree (
      .operands(flat),
      .sum     (tree_sum)
    );

    assign y = $signed(tree_sum);
  end else if (TYPE == TypeNormal) begin : g_chain
    logic signed [WIDTH_Y-1:0] acc;

    // Linear accumulate chain over all taps.
    always_comb begin
      acc = '0;
      for (int i = 0; i <= int'(N); i++) acc = acc + prods[i];
    end

    assign y = acc;
  end else begin : g_bad_type
    $error("fir_filter_core: unsupported TYPE %s", TYPE);
    assign y = '0;
  end

endmodule

// File: tb/tb_fir_filter_core.sv
// Self-checking bench: directed step/impulse/extreme/reset cases plus random
// stimulus, compared against a dot-product model over the sample history.
module tb_fir_filter_core;

  localparam logic [3:0] B3 [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  localparam logic [3:0] B0 [1] = '{4'hB};
  localparam logic [3:0] B7 [8] = '{4'h8, 4'h7, 4'hD, 4'h5, 4'h2, 4'hF, 4'h6, 4'hC};

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic signed [3:0] x    = '0;

  logic signed [11:0] y_normal;
  logic signed [11:0] y_tree;
  logic signed [8:0]  y_n0;
  logic signed [15:0] y_n7_normal;
  logic signed [15:0] y_n7_tree;

  int errors = 0;
  int checks = 0;

  // past[k] is the sample accepted k+1 edges ago (zero after reset).
  int past [8];
  int c3 [8];
  int c0 [8];
  int c7 [8];

  always #5 clk = ~clk;

  fir_filter_core #(.N(3), .TYPE("NORMAL"), .WIDTH_X(4), .WIDTH_B(4), .B(B3)) u_dut_normal (
    .clk(clk), .rstn(rstn), .x(x), .y(y_normal)
  );
  fir_filter_core #(.N(3), .TYPE("TREE"), .WIDTH_X(4), .WIDTH_B(4), .B(B3)) u_dut_tree (
    .clk(clk), .rstn(rstn), .x(x), .y(y_tree)
  );
  fir_filter_core #(.N(0), .TYPE("NORMAL"), .WIDTH_X(4), .WIDTH_B(4), .B(B0)) u_dut_n0 (
    .clk(clk), .rstn(rstn), .x(x), .y(y_n0)
  );
  fir_filter_core #(.N(7), .TYPE("NORMAL"), .WIDTH_X(4), .WIDTH_B(4), .B(B7)) u_dut_n7_normal (
    .clk(clk), .rstn(rstn), .x(x), .y(y_n7_normal)
  );
  fir_filter_core #(.N(7), .TYPE("TREE"), .WIDTH_X(4), .WIDTH_B(4), .B(B7)) u_dut_n7_tree (
    .clk(clk), .rstn(rstn), .x(x), .y(y_n7_tree)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int c [8], input int n);
    int acc;
    acc = c[0] * int'(x);
    for (int i = 1; i <= n; i++) acc += c[i] * past[i-1];
    return acc;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/n3_normal"}, y_normal,    model(c3, 3));
    check({tag, "/n3_tree"},   y_tree,      model(c3, 3));
    check({tag, "/n0"},        y_n0,        model(c0, 0));
    check({tag, "/n7_normal"}, y_n7_normal, model(c7, 7));
    check({tag, "/n7_tree"},   y_n7_tree,   model(c7, 7));
  endtask

  task automatic clear_history();
    for (int i = 0; i < 8; i++) past[i] = 0;
  endtask

  // Advance one clock; the model accepts x only when out of reset.
  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      for (int i = 7; i > 0; i--) past[i] = past[i-1];
      past[0] = int'(x);
    end
    #1;
  endtask

  task automatic set_x(input int v);
    x = 4'(v);
    #1;
  endtask

  initial begin
    int step_exp [5];
    int imp_x [6];
    int imp_exp [6];
    step_exp = '{1, 3, 6, 10, 10};
    imp_x    = '{1, 0, 0, 0, 0, 0};
    imp_exp  = '{1, 2, 3, 4, 0, 0};

    for (int i = 0; i < 8; i++) begin
      c3[i] = (i < 4) ? int'($signed(B3[i])) : 0;
      c0[i] = (i < 1) ? int'($signed(B0[0])) : 0;
      c7[i] = int'($signed(B7[i]));
    end
    clear_history();

    // Reset state: y follows B0*x only.
    #3;
    check("reset_zero", y_normal, 0);
    set_x(1);
    check("reset_b0x", y_normal, 1);
    check_all("reset");
    tick();
    check("reset_hold", y_normal, 1);
    check_all("reset_hold");

    // Step response from power-up.
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_x(1);
      check($sformatf("step%0d", k), y_normal, step_exp[k]);
      check_all("step");
      tick();
    end

    // Impulse response after a fresh reset pulse.
    rstn = 1'b0;
    clear_history();
    #1;
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_x(imp_x[k]);
      check($sformatf("impulse%0d", k), y_normal, imp_exp[k]);
      check_all("impulse");
      tick();
    end

    // Extremes held until the delay line is saturated.
    for (int k = 0; k < 5; k++) begin
      set_x(-8);
      check_all("neg_hold");
      tick();
    end
    set_x(-8);
    check("neg_settle", y_normal, -80);
    for (int k = 0; k < 5; k++) begin
      set_x(7);
      check_all("pos_hold");
      tick();
    end
    set_x(7);
    check("pos_settle", y_normal, 70);

    // Reset mid-stream, asserted between edges.
    for (int k = 0; k < 5; k++) begin
      set_x(5);
      tick();
    end
    #2;
    rstn = 1'b0;
    clear_history();
    #1;
    check("midrst_async", y_normal, 5);
    check_all("midrst_async");
    tick();
    check("midrst_hold", y_normal, 5);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_x(1);
      check($sformatf("restep%0d", k), y_normal, step_exp[k]);
      check_all("restep");
      tick();
    end

    // Random stream, with one reset pulse in the middle.
    for (int k = 0; k < 500; k++) begin
      if (k == 250) begin
        rstn = 1'b0;
        clear_history();
        #1;
        rstn = 1'b1;
      end
      set_x(int'($urandom_range(0, 15)));
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
